// File: rtl/bus_switch_controller.sv
// -----------------------------------------------------------------------------
// bus_switch_controller
//
// Chooses which source drives an intercepted bus line: the genuine
// pass-through path or the MITM injection core. Ownership changes only at
// frame boundaries, so a frame is always completed by the source that started
// it (reset is the one exception, where truncation is accepted).
//
// Parameters:
//   IDLE_LEVEL     - level of frame_sig while the bus is idle (1 = active-low CS)
//   IDLE_CYCLES    - consecutive idle cycles required before a grant (1..65535)
//   TIMEOUT_CYCLES - longest MITM hold before a forced release (1..2^24-1)
//
// Ports:
//   sys_clk        - system clock
//   reset          - synchronous, active-high reset
//   frame_sig      - frame delimiter, already synchronous to sys_clk
//   mitm_req       - MITM core requests the line (level, held until done)
//   mitm_grant     - MITM core owns the line (level, registered)
//   sel_mitm       - output mux select, 1 = MITM source drives (registered)
//   frame_start    - 1-cycle pulse on idle->active of frame_sig (combinational)
//   frame_end      - 1-cycle pulse on active->idle of frame_sig (combinational)
//   timeout        - 1-cycle pulse as a forced release begins (registered)
//   mitm_frame_cnt - [15:0] frames ended while sel_mitm=1; present only when
//                    MITM_FRAME_CNT_EN is defined
//
// Optional feature macro: MITM_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module bus_switch_controller #(
  parameter logic        IDLE_LEVEL     = 1'b1,
  parameter int unsigned IDLE_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        frame_sig,
  input  logic        mitm_req,
  output logic        mitm_grant,
  output logic        sel_mitm,
  output logic        frame_start,
  output logic        frame_end,
  output logic        timeout
`ifdef MITM_FRAME_CNT_EN
  ,
  output logic [15:0] mitm_frame_cnt
`endif
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    PASS,
    ARM,
    MITM,
    DRAIN
  } state_t;

  state_t        state;
  logic          prev;
  logic [IW-1:0] idle_cnt;
  logic [TW-1:0] to_cnt;
  logic          frame_idle;
  logic          prev_idle;
  logic          line_safe;

  // ---------------------------------------------------------------------------
  // Frame edge detection and idle tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    frame_idle  = (frame_sig == IDLE_LEVEL);
    prev_idle   = (prev == IDLE_LEVEL);
    frame_start = prev_idle & ~frame_idle;
    frame_end   = ~prev_idle & frame_idle;
    // A frame_start on the cycle the counter would saturate is not safe:
    // the current-cycle level gates the saturated count.
    line_safe   = (idle_cnt == IDLE_MAX) & frame_idle;
  end

  // Counter resets saturated so the line counts as idle straight out of reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      prev     <= IDLE_LEVEL;
      idle_cnt <= IDLE_MAX;
    end else begin
      prev <= frame_sig;
      if (!frame_idle) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ownership FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state          <= PASS;
      mitm_grant     <= 1'b0;
      sel_mitm       <= 1'b0;
      timeout        <= 1'b0;
      to_cnt         <= '0;
`ifdef MITM_FRAME_CNT_EN
      mitm_frame_cnt <= '0;
`endif
    end else begin
      timeout <= 1'b0;

`ifdef MITM_FRAME_CNT_EN
      // Counting is placed before the case so the clear on MITM entry wins.
      if (sel_mitm && frame_end) begin
        mitm_frame_cnt <= mitm_frame_cnt + 16'd1;
      end
`endif

      case (state)
        PASS: begin
          if (mitm_req) begin
            state <= ARM;
          end
        end

        ARM: begin
          if (!mitm_req) begin
            state <= PASS;
          end else if (line_safe) begin
            state          <= MITM;
            mitm_grant     <= 1'b1;
            sel_mitm       <= 1'b1;
            to_cnt         <= '0;
`ifdef MITM_FRAME_CNT_EN
            mitm_frame_cnt <= '0;
`endif
          end
        end

        MITM: begin
          to_cnt <= to_cnt + TW'(1);
          // Timeout takes priority so the pulse fires even if the request
          // drops on the same cycle.
          if (to_cnt == TO_LAST) begin
            state      <= DRAIN;
            mitm_grant <= 1'b0;
            timeout    <= 1'b1;
          end else if (!mitm_req) begin
            state      <= DRAIN;
            mitm_grant <= 1'b0;
          end
        end

        DRAIN: begin
          // The mux stays on MITM until the frame it started has ended;
          // an idle level covers both "already idle" and the frame_end cycle.
          if (frame_idle) begin
            state    <= PASS;
            sel_mitm <= 1'b0;
          end
        end

        default: begin
          state      <= PASS;
          mitm_grant <= 1'b0;
          sel_mitm   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  grant_implies_sel : assert property (
    @(posedge sys_clk) disable iff (reset) mitm_grant |-> sel_mitm
  );

  timeout_releases : assert property (
    @(posedge sys_clk) disable iff (reset) timeout |-> !mitm_grant
  );

endmodule

// File: tb/tb_bus_switch_controller.sv
module tb_bus_switch_controller;

  localparam logic IDLE  = 1'b1;
  localparam int   IDLE_N = 16;
  localparam int   TO_N   = 8;

  logic sys_clk = 1'b0;
  logic reset;
  logic frame_sig;
  logic mitm_req;
  logic mitm_grant;
  logic sel_mitm;
  logic frame_start;
  logic frame_end;
  logic timeout;
`ifdef MITM_FRAME_CNT_EN
  logic [15:0] mitm_frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bus_switch_controller #(
    .IDLE_LEVEL     (IDLE),
    .IDLE_CYCLES    (IDLE_N),
    .TIMEOUT_CYCLES (TO_N)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .frame_sig   (frame_sig),
    .mitm_req    (mitm_req),
    .mitm_grant  (mitm_grant),
    .sel_mitm    (sel_mitm),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .timeout     (timeout)
`ifdef MITM_FRAME_CNT_EN
    ,
    .mitm_frame_cnt (mitm_frame_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: who owns the line, expressed as ownership flags plus
  // plain counts of idle cycles seen and cycles held by the MITM core.
  bit m_prev;
  int m_idle_run;   // consecutive idle cycles completed before this one
  bit m_waiting;    // request seen, waiting for a safe line
  bit m_granted;    // MITM core currently owns the line
  bit m_draining;   // MITM released, current frame still finishing on MITM
  bit m_to;         // forced release happened at the last edge
  int m_held;       // MITM cycles completed under the current grant

  function automatic bit exp_start();
    return (m_prev == IDLE) && (frame_sig != IDLE);
  endfunction

  function automatic bit exp_end();
    return (m_prev != IDLE) && (frame_sig == IDLE);
  endfunction

  task automatic model_step();
    bit quiet;
    bit safe;
    if (reset) begin
      m_prev     = IDLE;
      m_idle_run = IDLE_N;
      m_waiting  = 0;
      m_granted  = 0;
      m_draining = 0;
      m_to       = 0;
      m_held     = 0;
    end else begin
      quiet = (frame_sig == IDLE);
      safe  = quiet && (m_idle_run >= IDLE_N);
      m_to  = 0;
      if (m_granted) begin
        m_held++;
        if (m_held == TO_N) begin
          m_granted = 0; m_draining = 1; m_to = 1;
        end else if (!mitm_req) begin
          m_granted = 0; m_draining = 1;
        end
      end else if (m_draining) begin
        if (quiet) m_draining = 0;
      end else if (m_waiting) begin
        if (!mitm_req) m_waiting = 0;
        else if (safe) begin
          m_waiting = 0; m_granted = 1; m_held = 0;
        end
      end else if (mitm_req) begin
        m_waiting = 1;
      end
      if (quiet) m_idle_run = (m_idle_run < 1000000) ? m_idle_run + 1 : m_idle_run;
      else m_idle_run = 0;
      m_prev = frame_sig;
    end
  endtask

  // Advance one clock; inputs are changed only after this returns.
  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  task automatic idle_line(input int n);
    frame_sig = IDLE;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_sig = IDLE; mitm_req = 1'b0;
    tick(); tick();
    checks++;
    if ({mitm_grant, sel_mitm, timeout, frame_start, frame_end} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {mitm_grant, sel_mitm, timeout, frame_start, frame_end});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({mitm_grant, sel_mitm} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_pass: got %b expected 00", {mitm_grant, sel_mitm});
    end
  endtask

  task automatic test_idle_grant();
    idle_line(20);
    mitm_req = 1'b1;
    tick();
    checks++;
    if ({mitm_grant, sel_mitm} !== 2'b00) begin
      errors++;
      $display("FAIL grant_T1: got %b expected 00", {mitm_grant, sel_mitm});
    end
    tick();
    checks++;
    if ({mitm_grant, sel_mitm} !== 2'b11) begin
      errors++;
      $display("FAIL grant_T2: got %b expected 11", {mitm_grant, sel_mitm});
    end
    mitm_req = 1'b0;
    tick();
    checks++;
    if ({mitm_grant, sel_mitm} !== 2'b01) begin
      errors++;
      $display("FAIL idle_drain: got %b expected 01", {mitm_grant, sel_mitm});
    end
    tick();
    checks++;
    if ({mitm_grant, sel_mitm} !== 2'b00) begin
      errors++;
      $display("FAIL idle_release: got %b expected 00", {mitm_grant, sel_mitm});
    end
  endtask

  task automatic test_frame_wait();
    int n;
    idle_line(20);
    mitm_req  = 1'b1;
    frame_sig = ~IDLE;
    #1;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_pulse: got %b expected 1", frame_start);
    end
    tick();
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL frame_start_single: got %b expected 0", frame_start);
    end
    repeat (38) begin
      tick();
      checks++;
      if (mitm_grant !== 1'b0) begin
        errors++;
        $display("FAIL grant_in_frame: got %b expected 0", mitm_grant);
      end
    end
    frame_sig = IDLE;
    #1;
    checks++;
    if (frame_end !== 1'b1) begin
      errors++;
      $display("FAIL frame_end_pulse: got %b expected 1", frame_end);
    end
    n = 0;
    while (mitm_grant !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (frame_end !== 1'b0) begin
          errors++;
          $display("FAIL frame_end_single: got %b expected 0", frame_end);
        end
      end
    end
    checks++;
    if (n != IDLE_N + 1) begin
      errors++;
      $display("FAIL grant_after_frame: got %0d cycles expected %0d", n, IDLE_N + 1);
    end
    mitm_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_drop_mid_frame();
    idle_line(20);
    mitm_req = 1'b1;
    tick(); tick();
    frame_sig = ~IDLE;
    tick(); tick();
    mitm_req = 1'b0;
    tick();
    checks++;
    if ({mitm_grant, sel_mitm} !== 2'b01) begin
      errors++;
      $display("FAIL drop_grant: got %b expected 01", {mitm_grant, sel_mitm});
    end
    repeat (4) begin
      tick();
      checks++;
      if (sel_mitm !== 1'b1) begin
        errors++;
        $display("FAIL drain_hold_sel: got %b expected 1", sel_mitm);
      end
    end
    frame_sig = IDLE;
    #1;
    checks++;
    if ({frame_end, sel_mitm} !== 2'b11) begin
      errors++;
      $display("FAIL drain_end_cycle: got %b expected 11", {frame_end, sel_mitm});
    end
    tick();
    checks++;
    if ({mitm_grant, sel_mitm} !== 2'b00) begin
      errors++;
      $display("FAIL drain_to_pass: got %b expected 00", {mitm_grant, sel_mitm});
    end
  endtask

  task automatic test_timeout();
    int n;
    idle_line(20);
    mitm_req = 1'b1;
    tick(); tick();
    frame_sig = ~IDLE;
    n = (mitm_grant === 1'b1) ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mitm_grant === 1'b1) n++;
      else break;
    end
    checks++;
    if (n != TO_N) begin
      errors++;
      $display("FAIL timeout_hold_len: got %0d expected %0d", n, TO_N);
    end
    checks++;
    if ({timeout, mitm_grant, sel_mitm} !== 3'b101) begin
      errors++;
      $display("FAIL timeout_pulse: got %b expected 101", {timeout, mitm_grant, sel_mitm});
    end
    repeat (10) begin
      tick();
      checks++;
      if ({timeout, mitm_grant, sel_mitm} !== 3'b001) begin
        errors++;
        $display("FAIL drain_ignores_req: got %b expected 001", {timeout, mitm_grant, sel_mitm});
      end
    end
    frame_sig = IDLE;
    n = 0;
    while (mitm_grant !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != IDLE_N + 1) begin
      errors++;
      $display("FAIL regrant_after_timeout: got %0d cycles expected %0d", n, IDLE_N + 1);
    end
    mitm_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_mitm();
    int n;
    idle_line(20);
    mitm_req = 1'b1;
    tick(); tick();
    frame_sig = ~IDLE;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({mitm_grant, sel_mitm} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_mitm: got %b expected 00", {mitm_grant, sel_mitm});
    end
    repeat (5) begin
      tick();
      checks++;
      if (mitm_grant !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_regrant: got %b expected 0", mitm_grant);
      end
    end
    frame_sig = IDLE;
    n = 0;
    while (mitm_grant !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != IDLE_N + 1) begin
      errors++;
      $display("FAIL grant_after_reset: got %0d cycles expected %0d", n, IDLE_N + 1);
    end
    mitm_req = 1'b0;
    tick(); tick();
  endtask

`ifdef MITM_FRAME_CNT_EN
  task automatic test_frame_cnt();
    idle_line(20);
    mitm_req = 1'b1;
    tick(); tick();
    repeat (3) begin
      frame_sig = ~IDLE; tick();
      frame_sig = IDLE;  tick();
    end
    checks++;
    if (mitm_frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt: got %0d expected 3", mitm_frame_cnt);
    end
    mitm_req = 1'b0;
    tick(); tick();
  endtask
`endif

  task automatic test_random();
    reset = 1'b1; frame_sig = IDLE; mitm_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < ((frame_sig == IDLE) ? 5 : 9)) frame_sig = ~frame_sig;
      if ($urandom_range(0, 99) < 4) mitm_req = ~mitm_req;
      reset = ($urandom_range(0, 999) < 3);
      #1;
      checks++;
      if (mitm_grant !== m_granted) begin
        errors++;
        $display("FAIL rnd_grant @%0d: got %b expected %b", i, mitm_grant, m_granted);
      end
      checks++;
      if (sel_mitm !== (m_granted | m_draining)) begin
        errors++;
        $display("FAIL rnd_sel @%0d: got %b expected %b", i, sel_mitm, m_granted | m_draining);
      end
      checks++;
      if (timeout !== m_to) begin
        errors++;
        $display("FAIL rnd_timeout @%0d: got %b expected %b", i, timeout, m_to);
      end
      checks++;
      if (frame_start !== exp_start()) begin
        errors++;
        $display("FAIL rnd_start @%0d: got %b expected %b", i, frame_start, exp_start());
      end
      checks++;
      if (frame_end !== exp_end()) begin
        errors++;
        $display("FAIL rnd_end @%0d: got %b expected %b", i, frame_end, exp_end());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_sig = IDLE; mitm_req = 1'b0;
    m_prev = IDLE; m_idle_run = IDLE_N; m_waiting = 0; m_granted = 0;
    m_draining = 0; m_to = 0; m_held = 0;
    test_reset();
    test_idle_grant();
    test_frame_wait();
    test_drop_mid_frame();
    test_timeout();
    test_reset_mid_mitm();
`ifdef MITM_FRAME_CNT_EN
    test_frame_cnt();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
